// File: rtl/pipelined_multiplier.sv
// Pipelined unsigned multiplier returning the low DATA_LEN bits of a*b.
// The b operand is consumed in slices, one slice per compute stage.
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
);
    localparam int SLICE_W = (DATA_LEN + PIPELINE_STAGE - 1) / PIPELINE_STAGE;

    // Index 0 is the input register; index k feeds compute stage k.
    logic [DATA_LEN-1:0] a_r   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] b_r   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] sum_r [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] term  [PIPELINE_STAGE];

    for (genvar k = 0; k < PIPELINE_STAGE; k++) begin : g_term
        localparam int OFF = k * SLICE_W;
        if (OFF < DATA_LEN) begin : g_live
            localparam int SW_K = (DATA_LEN - OFF < SLICE_W) ? DATA_LEN - OFF : SLICE_W;
            localparam logic [DATA_LEN-1:0] MASK = {DATA_LEN{1'b1}} >> (DATA_LEN - SW_K);
            // Multiplication in DATA_LEN context keeps only the low bits, which is all we need.
            assign term[k] = (a_r[k] << OFF) * ((b_r[k] >> OFF) & MASK);
        end else begin : g_empty
            // More stages than bits: trailing stages only pass the sum through.
            assign term[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < PIPELINE_STAGE; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
            end
        end else begin
            a_r[0]   <= a;
            b_r[0]   <= b;
            sum_r[0] <= term[0];
            for (int k = 1; k < PIPELINE_STAGE; k++) begin
                a_r[k]   <= a_r[k-1];
                b_r[k]   <= b_r[k-1];
                sum_r[k] <= sum_r[k-1] + term[k];
            end
        end
    end

    assign result = sum_r[PIPELINE_STAGE-1];
endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;
    localparam int NI = 4;

    function automatic int dl_of(input int i);
        case (i)
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int ps_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        return (dl_of(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << dl_of(i)) - 32'd1);
    endfunction

    typedef struct {
        logic [31:0] prod;
        bit          rst;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res [NI];

    exp_t sb [NI][$];
    int   n_chk;
    int   n_fail;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DL = dl_of(g);
        localparam int PS = ps_of(g);
        logic [DL-1:0] r;
        pipelined_multiplier #(.DATA_LEN(DL), .PIPELINE_STAGE(PS)) u_dut (
            .clk    (clk),
            .reset  (reset),
            .a      (a[DL-1:0]),
            .b      (b[DL-1:0]),
            .result (r)
        );
        assign res[g] = 32'(r);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input bit rv);
        a     = av;
        b     = bv;
        reset = rv;
        for (int i = 0; i < NI; i++) begin
            logic [63:0] m;
            logic [63:0] p;
            exp_t        e;
            m = {32'd0, mask_of(i)};
            p = (({32'd0, av} & m) * ({32'd0, bv} & m)) & m;
            e.prod = rv ? 32'd0 : p[31:0];
            e.rst  = rv;
            sb[i].push_back(e);
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (sb[i].size() == ps_of(i) + 1) begin : chk
                logic [31:0] exp_v;
                exp_v = sb[i][0].prod;
                for (int j = 0; j <= ps_of(i); j++)
                    if (sb[i][j].rst) exp_v = 32'd0;
                n_chk++;
                if (res[i] !== exp_v) begin
                    n_fail++;
                    $display("FAIL result cfg%0d (DL=%0d PS=%0d) t=%0t: got 0x%08h expected 0x%08h",
                             i, dl_of(i), ps_of(i), $time, res[i], exp_v);
                end
                void'(sb[i].pop_front());
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        a      = '0;
        b      = '0;
        reset  = 1'b1;
        repeat (6) drive(32'd0, 32'd0, 1'b1);

        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if (res[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset state cfg%0d t=%0t: got 0x%08h expected 0", i, $time, res[i]);
            end
        end

        drive(32'd3, 32'd5, 1'b0);
        repeat (2) drive(32'd0, 32'd0, 1'b0);
        n_chk++;
        if (res[0] !== 32'd15) begin
            n_fail++;
            $display("FAIL basic wait cfg0 t=%0t: got 0x%08h expected 0x0000000f", $time, res[0]);
        end
        repeat (3) drive(32'd0, 32'd0, 1'b0);

        drive(32'hFFFF_FFFF, 32'd2, 1'b0);
        drive(32'h0001_0000, 32'h0001_0000, 1'b0);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drive(32'h0000_00FF, 32'h0000_00FF, 1'b0);

        drive(32'd2, 32'd3, 1'b0);
        drive(32'd7, 32'd6, 1'b0);
        drive(32'd1000, 32'd1000, 1'b0);
        drive(32'd0, 32'd9, 1'b0);

        drive(32'd12345, 32'd1, 1'b0);
        drive(32'd0, 32'hDEAD_BEEF, 1'b0);
        drive(32'd1, 32'h8000_0000, 1'b0);
        repeat (5) drive(32'd0, 32'd0, 1'b0);

        drive(32'd9, 32'd9, 1'b0);
        drive(32'd0, 32'd0, 1'b1);
        repeat (5) drive(32'd0, 32'd0, 1'b0);
        drive(32'd4, 32'd4, 1'b0);
        repeat (5) drive(32'd0, 32'd0, 1'b0);

        drive(32'd77, 32'd77, 1'b1);
        drive(32'd5, 32'd6, 1'b0);
        drive(32'd8, 32'd9, 1'b0);
        repeat (3) drive(32'd11, 32'd13, 1'b1);
        repeat (5) drive(32'd0, 32'd0, 1'b0);

        for (int n = 0; n < 1000; n++)
            drive($urandom, $urandom, ($urandom_range(0, 49) == 0));

        repeat (8) drive(32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
